stream_mux_arb: RTL
===================

Name: stream_mux_arb

Overview:
- Parametrised N-to-1 operand/stream multiplexer; successor to the fixed 8-bit two-input select mux.
- Configurable data width and channel count.
- Per-channel valid/ready handshakes and a registered output stage.
- Runtime mode: externally selected channel, or round-robin arbitration.
- Sits between the register-file/forwarding sources and the ALU/writeback operand buses of the 16-bit core.

Parameters:
- WIDTH, 16, data width per channel in bits (>=1).
- N, 4, number of input channels (>=2).
- SELW, $clog2(N), select/source index width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel data valid.
- in_ready  output  N  per-channel accept; combinational.
- mode  input  1  0 = SELECT, 1 = ROUND_ROBIN.
- sel  input  SELW  channel index used in SELECT mode.
- out_data  output  WIDTH  registered selected data.
- out_src  output  SELW  registered index of the channel that supplied out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, out_data=0, out_src=0, rr_ptr=0. in_ready is all-zero while rst=0.
- Load enable: load = ~out_valid | out_ready. The output register accepts one beat per cycle, giving full throughput with 1-cycle latency from input handshake to out_valid.
- Grant is computed combinationally each cycle; at most one grant bit is set.
- SELECT mode:
  - grant[sel] = in_valid[sel] & load.
  - If sel >= N, no grant.
- ROUND_ROBIN mode:
  - grant goes to the first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo N.
  - Grant is issued only when load=1.
- Handshake and register update:
  - in_ready[i] = grant[i]. A transfer occurs on channel i when in_valid[i] & in_ready[i].
  - On a transfer: out_data <= channel data, out_src <= i, out_valid <= 1.
  - If load=1 and no transfer: out_valid <= 0; out_data and out_src hold.
  - If load=0: all outputs hold (stall). out_data and out_src are stable while out_valid=1 & out_ready=0.
- rr_ptr:
  - Updates only on a ROUND_ROBIN transfer: rr_ptr <= (i == N-1) ? 0 : i+1. Wrap-around is explicit, not a power-of-two mask.
  - Unchanged in SELECT mode.
- Mode or sel changes take effect in the same cycle's grant; a beat already registered is unaffected.
- Simultaneous events:
  - Downstream pop and new accept in the same cycle is allowed: out_valid stays 1 and data is replaced.
  - All in_valid high in ROUND_ROBIN with out_ready=1 yields grants 0,1,2,3,0… on consecutive cycles.
- Reset mid-transfer: the in-flight beat is dropped and outputs return to reset values immediately. No beat is accepted while rst=0.
- Inputs need not hold data stable without a grant; only granted data is sampled.

Decomposition:
- Package stream_mux_pkg: MODE_SELECT=1'b0 and MODE_RR=1'b1 constants, and a sel_idx_t helper typedef sized by a package-level default N.
- Sub-module rr_arbiter (parameters N; inputs req[N], ptr, en; output one-hot grant[N]). Handles the rotating priority search and wrap.
- Top level holds the mux, output register, and rr_ptr.

Test Plan:
- Reset: assert rst=0 with all in_valid=1 -> out_valid=0, out_data=0, out_src=0, in_ready=4'b0000. Release rst -> first beat appears 1 cycle after the grant.
- SELECT, WIDTH=16, N=4: sel=2, in_valid=4'b0100, ch2=16'hA5A5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=16'hA5A5, out_src=2, out_valid=1. Then sel=3 with in_valid[3]=0 -> out_valid drops to 0.
- Backpressure: out_valid=1 with out_ready=0 for 3 cycles while ch1 is valid -> in_ready=0 and out_data/out_src hold. Raise out_ready -> ch1 accepted and replaces the output in the same cycle.
- ROUND_ROBIN: all four channels valid, out_ready=1 -> out_src sequence 0,1,2,3,0 on consecutive cycles. With in_valid=4'b1001 starting from rr_ptr=1 -> grants 3,0,3,0.
- Wrap and mode switch: in RR, grant ch3 -> rr_ptr=0. Switch to SELECT with sel=1 -> ch1 granted and rr_ptr stays 0. Switch back to RR -> search restarts at ch0.
- Mid-transfer reset: pulse rst low asynchronously while out_valid=1 and a grant is pending -> outputs clear immediately, no beat is delivered, and rr_ptr=0 after release.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants and types for the N-to-1 operand/stream multiplexer.
package stream_mux_pkg;

    localparam logic MODE_SELECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    localparam int DEFAULT_N = 4;
    typedef logic [$clog2(DEFAULT_N)-1:0] sel_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
    parameter int N = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    grant
);

    logic [SELW-1:0] idx;
    logic            found;

    // Wrap is an explicit compare so non-power-of-two N rotates correctly.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < N; k++) begin
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
            idx = (idx == SELW'(N - 1)) ? '0 : idx + 1'b1;
        end
        if (!en) begin
            grant = '0;
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-to-1 stream multiplexer with select or round-robin source choice and a
// registered, back-pressurable output stage.
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_src,
    output logic               out_valid,
    input  logic               out_ready
);

    // Handshake: a beat moves on any side when valid & ready are both high at a
    // rising clk edge; in_ready never depends on in_data, out_valid never waits on out_ready.
    logic             load;
    logic [SELW-1:0]  rr_ptr;
    logic [N-1:0]     sel_grant;
    logic [N-1:0]     rr_grant;
    logic [N-1:0]     grant;
    logic [WIDTH-1:0] grant_data;
    logic [SELW-1:0]  grant_src;
    logic             xfer;

    assign load = ~out_valid | out_ready;

    // An out-of-range sel matches no channel index, so it grants nothing.
    always_comb begin
        sel_grant = '0;
        for (int i = 0; i < N; i++) begin
            sel_grant[i] = (sel == SELW'(i)) & in_valid[i];
        end
    end

    rr_arbiter #(.N(N)) u_rr_arbiter (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .en    (load & rst & (mode == MODE_RR)),
        .grant (rr_grant)
    );

    always_comb begin
        grant = '0;
        if (rst && load) begin
            grant = (mode == MODE_RR) ? rr_grant : sel_grant;
        end
    end

    assign in_ready = grant;
    assign xfer     = |grant;

    always_comb begin
        grant_data = '0;
        grant_src  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
                grant_src  = SELW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_src   <= grant_src;
                if (mode == MODE_RR) begin
                    rr_ptr <= (grant_src == SELW'(N - 1)) ? '0 : grant_src + 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
